// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory access arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_DATA   = 2'd2,
      ST_HALTED = 2'd3
   } arb_state_t;

   localparam int MAX_DATA_RUN_DEF = 4;
   localparam int TIMEOUT_DEF      = 15;

   // Bits needed to hold any value in 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Cycle counter for one memory access; flags the last allowed cycle before abort.
module arb_timeout_ctr
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CW = cnt_width(TIMEOUT - 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] to_cnt;

   // Saturates at LAST so a stuck access cannot wrap and re-arm the abort.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         to_cnt <= '0;
      end else if (enable && to_cnt != LAST) begin
         to_cnt <= to_cnt + CW'(1);
      end
   end

   assign expire = enable && (to_cnt == LAST);

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and data accesses,
// holding each command stable until mem_done or a timeout abort.
module mem_access_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW           = 16,
   parameter int DW           = 16,
   parameter int MAX_DATA_RUN = MAX_DATA_RUN_DEF,
   parameter int TIMEOUT      = TIMEOUT_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   input  logic          d_rd,
   input  logic          d_wr,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   input  logic          halt,
   output logic          mem_en,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_done,
   output logic [DW-1:0] if_rdata,
   output logic          if_valid,
   output logic          if_stall,
   output logic [DW-1:0] d_rdata,
   output logic          d_valid,
   output logic          d_stall,
   output logic          err,
   output logic          halted
);

   localparam int RW = cnt_width(MAX_DATA_RUN);
   localparam logic [RW-1:0] RUN_MAX = RW'(MAX_DATA_RUN);

   arb_state_t    state, state_next;
   logic [RW-1:0] run_cnt;
   logic          d_req, fetch_ok, in_access, grant_data, grant_fetch;
   logic          expire, to_clear;

   assign d_req       = d_rd | d_wr;
   assign fetch_ok    = if_req & ~halt;
   assign in_access   = (state == ST_FETCH) || (state == ST_DATA);
   // Data wins unless fetch has already waited through MAX_DATA_RUN data grants.
   assign grant_data  = (state == ST_IDLE) && d_req && !(fetch_ok && run_cnt == RUN_MAX);
   assign grant_fetch = (state == ST_IDLE) && !grant_data && fetch_ok;
   assign to_clear    = !in_access || mem_done || expire;

   arb_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (to_clear),
      .enable (in_access),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (grant_data) begin
               state_next = ST_DATA;
            end else if (grant_fetch) begin
               state_next = ST_FETCH;
            end else if (halt && !d_req) begin
               state_next = ST_HALTED;
            end
         end
         ST_FETCH, ST_DATA: begin
            if (mem_done || expire) begin
               state_next = ST_IDLE;
            end
         end
         ST_HALTED: state_next = ST_HALTED;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      if_stall = if_req && !((state == ST_FETCH) && mem_done);
      d_stall  = d_req && !((state == ST_DATA) && mem_done);
   end

   // Command, result and status registers; an aborted access returns zero read data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         if_valid  <= 1'b0;
         d_rdata   <= '0;
         d_valid   <= 1'b0;
         err       <= 1'b0;
         halted    <= 1'b0;
         run_cnt   <= '0;
      end else begin
         mem_en   <= (state_next == ST_FETCH) || (state_next == ST_DATA);
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         err      <= 1'b0;
         if (grant_data) begin
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wr    <= d_wr;
            if (!if_req) begin
               run_cnt <= '0;
            end else if (run_cnt != RUN_MAX) begin
               run_cnt <= run_cnt + RW'(1);
            end
         end else if (grant_fetch) begin
            mem_addr <= if_addr;
            mem_wr   <= 1'b0;
            run_cnt  <= '0;
         end
         if ((state == ST_FETCH) && (mem_done || expire)) begin
            if_valid <= 1'b1;
            if_rdata <= mem_done ? mem_rdata : '0;
         end
         if ((state == ST_DATA) && (mem_done || expire)) begin
            d_valid <= 1'b1;
            if (!mem_wr) begin
               d_rdata <= mem_done ? mem_rdata : '0;
            end
         end
         if (in_access && expire && !mem_done) begin
            err <= 1'b1;
         end
         if (state_next == ST_HALTED) begin
            halted <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: a latency-programmable memory model plus
// scoreboard queues of expected commands and read results.
module tb_mem_access_arbiter;

   localparam int K_EN  = 0;
   localparam int K_IFV = 1;
   localparam int K_DV  = 2;
   localparam int K_ERR = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0, d_rd = 1'b0, d_wr = 1'b0, halt = 1'b0;
   logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0;
   logic        mem_en, mem_wr, if_valid, if_stall, d_valid, d_stall, err, halted;
   logic [15:0] mem_addr, mem_wdata, if_rdata, d_rdata;
   logic [15:0] mem_rdata = '0;
   logic        mem_done = 1'b0;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
   } cmd_t;

   cmd_t        exp_cmd[$];
   logic [15:0] exp_rd[$];
   int          tests_run = 0;
   int          tests_failed = 0;
   int          mem_lat = -1;
   int          en_cnt = 0;

   mem_access_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .d_rd      (d_rd),
      .d_wr      (d_wr),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .halt      (halt),
      .mem_en    (mem_en),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_done  (mem_done),
      .if_rdata  (if_rdata),
      .if_valid  (if_valid),
      .if_stall  (if_stall),
      .d_rdata   (d_rdata),
      .d_valid   (d_valid),
      .d_stall   (d_stall),
      .err       (err),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   // Memory answers mem_lat cycles after the first mem_en cycle; -1 never answers.
   always @(negedge clk) begin
      if (!mem_en) begin
         en_cnt    = 0;
         mem_done  = 1'b0;
         mem_rdata = 16'hDEAD;
      end else begin
         mem_done  = (en_cnt == mem_lat);
         mem_rdata = mem_done ? (mem_addr ^ 16'hA5A5) : 16'hDEAD;
         en_cnt++;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic ifr, input logic [15:0] ia, input logic dr,
                                 input logic dw, input logic [15:0] da,
                                 input logic [15:0] dwd, input logic h);
      if_req  = ifr;
      if_addr = ia;
      d_rd    = dr;
      d_wr    = dw;
      d_addr  = da;
      d_wdata = dwd;
      halt    = h;
   endtask

   task automatic reset_dut(input string tag);
      rst_n = 1'b0;
      apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      repeat (3) @(negedge clk);
      check_output({tag, "_ctl"}, {mem_en, mem_wr, if_valid, d_valid, err, halted}, 32'd0);
      check_output({tag, "_cmd"}, {mem_addr, mem_wdata}, 32'd0);
      check_output({tag, "_rdata"}, {if_rdata, d_rdata}, 32'd0);
      rst_n = 1'b1;
   endtask

   task automatic wait_event(input int kind, input int budget, input string tag,
                             output int cycles);
      bit seen;
      seen   = 1'b0;
      cycles = 0;
      while (!seen && cycles < budget) begin
         @(negedge clk);
         cycles++;
         case (kind)
            K_EN:    seen = mem_en;
            K_IFV:   seen = if_valid;
            K_DV:    seen = d_valid;
            default: seen = err;
         endcase
      end
      check_output({tag, "_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic expect_grant(input string tag);
      int   cyc;
      cmd_t c;
      wait_event(K_EN, 40, tag, cyc);
      check_output({tag, "_sb"}, 32'(exp_cmd.size() > 0), 32'd1);
      if (exp_cmd.size() > 0) begin
         c = exp_cmd.pop_front();
         check_output({tag, "_wr"}, 32'(mem_wr), 32'(c.wr));
         check_output({tag, "_addr"}, 32'(mem_addr), 32'(c.addr));
         if (c.wr) check_output({tag, "_wdata"}, 32'(mem_wdata), 32'(c.wdata));
      end
   endtask

   task automatic expect_read(input int kind, input string tag, output int cyc);
      logic [15:0] e;
      wait_event(kind, 40, tag, cyc);
      check_output({tag, "_sb"}, 32'(exp_rd.size() > 0), 32'd1);
      if (exp_rd.size() > 0) begin
         e = exp_rd.pop_front();
         check_output({tag, "_rdata"}, 32'((kind == K_IFV) ? if_rdata : d_rdata), 32'(e));
      end
   endtask

   initial begin
      int cyc;
      int en_seen;

      reset_dut("reset");

      // Fetch alone, memory answers 3 cycles after mem_en.
      mem_lat = 3;
      exp_cmd.push_back('{1'b0, 16'h0040, 16'h0000});
      exp_rd.push_back(16'h0040 ^ 16'hA5A5);
      apply_stimulus(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      expect_grant("t1_grant");
      #1 check_output("t1_if_stall", 32'(if_stall), 32'd1);
      expect_read(K_IFV, "t1_if", cyc);
      check_output("t1_latency", 32'(cyc), 32'd4);
      apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      check_output("t1_pulse", {if_valid, mem_en}, 32'd0);

      // Simultaneous fetch and write: write first, fetch stalled throughout.
      mem_lat = 1;
      exp_cmd.push_back('{1'b1, 16'h1000, 16'hBEEF});
      exp_cmd.push_back('{1'b0, 16'h0200, 16'h0000});
      exp_rd.push_back(16'h0200 ^ 16'hA5A5);
      apply_stimulus(1'b1, 16'h0200, 1'b0, 1'b1, 16'h1000, 16'hBEEF, 1'b0);
      expect_grant("t2_wr");
      #1 check_output("t2_stalls_busy", {if_stall, d_stall}, 32'b11);
      @(negedge clk);
      #1 check_output("t2_stalls_done", {if_stall, d_stall}, 32'b10);
      wait_event(K_DV, 40, "t2_dv", cyc);
      check_output("t2_wr_no_capture", 32'(d_rdata), 32'd0);
      check_output("t2_if_stall_idle", 32'(if_stall), 32'd1);
      apply_stimulus(1'b1, 16'h0200, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      expect_grant("t2_fetch");
      expect_read(K_IFV, "t2_if", cyc);
      apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

      // Continuous data reads with fetch pending: 4 data grants then 1 fetch, twice.
      mem_lat = 0;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++) exp_cmd.push_back('{1'b0, 16'h3000, 16'h0000});
         exp_cmd.push_back('{1'b0, 16'h0300, 16'h0000});
      end
      apply_stimulus(1'b1, 16'h0300, 1'b1, 1'b0, 16'h3000, 16'h0, 1'b0);
      for (int g = 0; g < 10; g++) expect_grant($sformatf("t3_g%0d", g));
      apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      wait_event(K_IFV, 40, "t3_if", cyc);
      check_output("t3_if_rdata", 32'(if_rdata), 32'(16'h0300 ^ 16'hA5A5));
      check_output("t3_d_rdata", 32'(d_rdata), 32'(16'h3000 ^ 16'hA5A5));

      // Memory never answers: abort after 15 cycles in DATA.
      mem_lat = -1;
      exp_cmd.push_back('{1'b0, 16'h4000, 16'h0000});
      exp_rd.push_back(16'h0000);
      apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h4000, 16'h0, 1'b0);
      expect_grant("t4_grant");
      wait_event(K_ERR, 40, "t4_err", cyc);
      check_output("t4_cycles", 32'(cyc), 32'd15);
      check_output("t4_dvalid", 32'(d_valid), 32'd1);
      check_output("t4_rdata_zero", 32'(d_rdata), 32'(exp_rd.pop_front()));
      apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      check_output("t4_after", {err, d_valid, mem_en}, 32'd0);

      // Halt during fetch with a data read pending.
      mem_lat = 2;
      exp_cmd.push_back('{1'b0, 16'h0500, 16'h0000});
      exp_rd.push_back(16'h0500 ^ 16'hA5A5);
      apply_stimulus(1'b1, 16'h0500, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      expect_grant("t5_fetch");
      exp_cmd.push_back('{1'b0, 16'h5000, 16'h0000});
      exp_rd.push_back(16'h5000 ^ 16'hA5A5);
      apply_stimulus(1'b1, 16'h0500, 1'b1, 1'b0, 16'h5000, 16'h0, 1'b1);
      expect_read(K_IFV, "t5_if", cyc);
      expect_grant("t5_data");
      expect_read(K_DV, "t5_d", cyc);
      apply_stimulus(1'b1, 16'h0500, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      @(negedge clk);
      check_output("t5_halted", 32'(halted), 32'd1);
      en_seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (mem_en) en_seen++;
      end
      check_output("t5_no_grant", 32'(en_seen), 32'd0);
      #1 check_output("t5_halted_stalls", {halted, if_stall, d_stall}, 32'b110);

      // Reset mid-DATA, then simultaneous read+write issues a write.
      reset_dut("t6_reset");
      mem_lat = -1;
      exp_cmd.push_back('{1'b0, 16'h6000, 16'h0000});
      apply_stimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h6000, 16'h0, 1'b0);
      expect_grant("t6_rd");
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_output("t6_mid_reset", {mem_en, d_valid, err, halted}, 32'd0);
      rst_n   = 1'b1;
      mem_lat = 1;
      exp_cmd.push_back('{1'b1, 16'h6100, 16'h1234});
      apply_stimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h6100, 16'h1234, 1'b0);
      #1 check_output("t6_d_stall_idle", 32'(d_stall), 32'd1);
      expect_grant("t6_wr");
      wait_event(K_DV, 40, "t6_dv", cyc);
      check_output("t6_wr_no_capture", 32'(d_rdata), 32'd0);
      apply_stimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);

      check_output("sb_drain", 32'(exp_cmd.size() + exp_rd.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
